// File: rtl/issue_unit.sv
// issue_unit: one-entry in-order issue slot fed by the instruction queue.
// It holds entries on RAW hazards and forwards writeback data into the slot.
module issue_unit #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int CTRL_W = 63,
  parameter int SCNT_W = 16
) (
  input  logic              is_clk,
  input  logic              is_rst,
  input  logic              is_i_q_empty,
  output logic              is_o_q_re,
  input  logic [AWIDTH-1:0] is_i_addr_rs,
  input  logic [AWIDTH-1:0] is_i_addr_rt,
  input  logic [AWIDTH-1:0] is_i_addr_rd,
  input  logic [DWIDTH-1:0] is_i_data_rs,
  input  logic [DWIDTH-1:0] is_i_data_rt,
  input  logic              is_i_reg_dst,
  input  logic              is_i_regwrite,
  input  logic [CTRL_W-1:0] is_i_ctrl,
  input  logic              is_i_exe_rdy,
  input  logic              is_i_wb_en,
  input  logic [AWIDTH-1:0] is_i_wb_addr,
  input  logic [DWIDTH-1:0] is_i_wb_data,
  input  logic              is_i_flush,
  output logic              is_o_valid,
  output logic [DWIDTH-1:0] is_o_data_rs,
  output logic [DWIDTH-1:0] is_o_data_rt,
  output logic [AWIDTH-1:0] is_o_dest,
  output logic              is_o_regwrite,
  output logic [CTRL_W-1:0] is_o_ctrl,
  output logic [SCNT_W-1:0] is_o_stall_cnt
);

  localparam int NREG     = 1 << AWIDTH;
  // Bit positions inside the packed control bundle (LSB = jal_addr[0]).
  localparam int B_JAL    = 54;
  localparam int B_MEMWR  = 56;
  localparam int B_ALUSRC = 58;

  typedef enum logic {
    S_IDLE,
    S_CAP
  } state_e;

  state_e state_q, state_d;

  logic              slot_v_q, slot_v_d;
  logic [AWIDTH-1:0] rs_q, rs_d;
  logic [AWIDTH-1:0] rt_q, rt_d;
  logic [DWIDTH-1:0] drs_q, drs_d;
  logic [DWIDTH-1:0] drt_q, drt_d;
  logic [AWIDTH-1:0] dest_q, dest_d;
  logic              rw_q, rw_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic [NREG-1:0]   busy_q, busy_d;
  logic [SCNT_W-1:0] stall_q, stall_d;

  logic              ov_q, ov_d;
  logic [DWIDTH-1:0] ors_q, ors_d;
  logic [DWIDTH-1:0] ort_q, ort_d;
  logic [AWIDTH-1:0] odst_q, odst_d;
  logic              orw_q, orw_d;
  logic [CTRL_W-1:0] octl_q, octl_d;

  logic              rt_used;
  logic              hazard;
  logic              issue_now;
  logic              issue;
  logic [AWIDTH-1:0] in_dest;

  assign rt_used   = !ctrl_q[B_ALUSRC] || ctrl_q[B_MEMWR];
  assign hazard    = busy_q[rs_q]
                   || (rt_used && busy_q[rt_q]);
  assign issue_now = slot_v_q && !hazard && is_i_exe_rdy;
  assign issue     = issue_now && !is_i_flush;

  assign in_dest = is_i_ctrl[B_JAL] ? {AWIDTH{1'b1}}
                 : is_i_reg_dst     ? is_i_addr_rd
                 :                    is_i_addr_rt;

  // FSM: state register
  always_ff @(posedge is_clk) begin
    if (!is_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (is_i_flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (is_o_q_re) state_d = S_CAP;
        S_CAP:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    is_o_q_re = 1'b0;
    if (state_q == S_IDLE) begin
      is_o_q_re = is_rst && !is_i_q_empty
               && (!slot_v_q || issue_now)
               && !is_i_flush;
    end
  end

  always_comb begin
    slot_v_d = slot_v_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    drs_d    = drs_q;
    drt_d    = drt_q;
    dest_d   = dest_q;
    rw_d     = rw_q;
    ctrl_d   = ctrl_q;
    if (issue) begin
      slot_v_d = 1'b0;
    end
    if (slot_v_q && is_i_wb_en) begin
      if (is_i_wb_addr == rs_q) drs_d = is_i_wb_data;
      if (is_i_wb_addr == rt_q) drt_d = is_i_wb_data;
    end
    // Queue outputs are valid in CAP; forward a coincident writeback.
    if (state_q == S_CAP) begin
      slot_v_d = 1'b1;
      rs_d     = is_i_addr_rs;
      rt_d     = is_i_addr_rt;
      dest_d   = in_dest;
      rw_d     = is_i_regwrite;
      ctrl_d   = is_i_ctrl;
      drs_d    = (is_i_wb_en && is_i_wb_addr == is_i_addr_rs)
               ? is_i_wb_data : is_i_data_rs;
      drt_d    = (is_i_wb_en && is_i_wb_addr == is_i_addr_rt)
               ? is_i_wb_data : is_i_data_rt;
    end
    if (is_i_flush) begin
      slot_v_d = 1'b0;
    end
  end

  // Set after clear so an issue racing its own writeback keeps busy.
  always_comb begin
    busy_d = busy_q;
    if (is_i_wb_en) begin
      busy_d[is_i_wb_addr] = 1'b0;
    end
    if (issue && rw_q && dest_q != '0) begin
      busy_d[dest_q] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    stall_d = stall_q;
    if (slot_v_q && hazard && stall_q != {SCNT_W{1'b1}}) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_comb begin
    ov_d   = issue;
    ors_d  = ors_q;
    ort_d  = ort_q;
    odst_d = odst_q;
    orw_d  = orw_q;
    octl_d = octl_q;
    if (issue) begin
      ors_d  = drs_q;
      ort_d  = drt_q;
      odst_d = dest_q;
      orw_d  = rw_q;
      octl_d = ctrl_q;
    end
  end

  always_ff @(posedge is_clk) begin
    if (!is_rst) begin
      slot_v_q <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      drs_q    <= '0;
      drt_q    <= '0;
      dest_q   <= '0;
      rw_q     <= 1'b0;
      ctrl_q   <= '0;
      busy_q   <= '0;
      stall_q  <= '0;
      ov_q     <= 1'b0;
      ors_q    <= '0;
      ort_q    <= '0;
      odst_q   <= '0;
      orw_q    <= 1'b0;
      octl_q   <= '0;
    end else begin
      slot_v_q <= slot_v_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      drs_q    <= drs_d;
      drt_q    <= drt_d;
      dest_q   <= dest_d;
      rw_q     <= rw_d;
      ctrl_q   <= ctrl_d;
      busy_q   <= busy_d;
      stall_q  <= stall_d;
      ov_q     <= ov_d;
      ors_q    <= ors_d;
      ort_q    <= ort_d;
      odst_q   <= odst_d;
      orw_q    <= orw_d;
      octl_q   <= octl_d;
    end
  end

  assign is_o_valid     = ov_q;
  assign is_o_data_rs   = ors_q;
  assign is_o_data_rt   = ort_q;
  assign is_o_dest      = odst_q;
  assign is_o_regwrite  = orw_q;
  assign is_o_ctrl      = octl_q;
  assign is_o_stall_cnt = stall_q;

endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: queue model drives the issue unit; expected issues
// go to a scoreboard that a negedge monitor drains and compares.
module tb_issue_unit;

  logic        clk = 1'b0;
  logic        is_rst;
  logic        q_empty;
  logic        q_re;
  logic        exe_rdy;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        o_valid;
  logic [31:0] o_rs;
  logic [31:0] o_rt;
  logic [4:0]  o_dest;
  logic        o_rw;
  logic [62:0] o_ctrl;
  logic [15:0] o_stall;

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [31:0] drs, drt;
    logic        reg_dst, rw;
    logic [62:0] ctrl;
  } ent_t;

  typedef struct packed {
    logic [31:0] drs, drt;
    logic [4:0]  dest;
    logic        rw;
    logic [62:0] ctrl;
  } exp_t;

  ent_t fifo[$];
  ent_t cur;
  exp_t sb[$];
  logic re_seen = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  issue_unit dut (
    .is_clk        (clk),
    .is_rst        (is_rst),
    .is_i_q_empty  (q_empty),
    .is_o_q_re     (q_re),
    .is_i_addr_rs  (cur.rs),
    .is_i_addr_rt  (cur.rt),
    .is_i_addr_rd  (cur.rd),
    .is_i_data_rs  (cur.drs),
    .is_i_data_rt  (cur.drt),
    .is_i_reg_dst  (cur.reg_dst),
    .is_i_regwrite (cur.rw),
    .is_i_ctrl     (cur.ctrl),
    .is_i_exe_rdy  (exe_rdy),
    .is_i_wb_en    (wb_en),
    .is_i_wb_addr  (wb_addr),
    .is_i_wb_data  (wb_data),
    .is_i_flush    (flush),
    .is_o_valid    (o_valid),
    .is_o_data_rs  (o_rs),
    .is_o_data_rt  (o_rt),
    .is_o_dest     (o_dest),
    .is_o_regwrite (o_rw),
    .is_o_ctrl     (o_ctrl),
    .is_o_stall_cnt(o_stall)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) re_seen = q_re;

  // Queue model: data of the popped entry appears the cycle after re.
  always @(posedge clk) begin
    #1;
    if (re_seen && fifo.size() > 0) cur = fifo.pop_front();
    q_empty = (fifo.size() == 0);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (is_rst && o_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue act=%h exp=none", o_rs);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("iss_rs", {32'h0, o_rs}, {32'h0, e.drs});
        chk("iss_rt", {32'h0, o_rt}, {32'h0, e.drt});
        chk("iss_dest", {59'h0, o_dest}, {59'h0, e.dest});
        chk("iss_rw", {63'h0, o_rw}, {63'h0, e.rw});
        chk("iss_ctrl", {1'b0, o_ctrl}, {1'b0, e.ctrl});
      end
    end
  end

  function automatic logic [62:0] mkc(input logic alu_src,
    input logic memwr, input logic jal, input logic [15:0] imm);
    logic [62:0] c;
    c = '0;
    c[59] = 1'b1;
    c[58] = alu_src;
    c[56] = memwr;
    c[54] = jal;
    c[41:26] = imm;
    c[25:0] = {10'h0, imm};
    return c;
  endfunction

  function automatic ent_t mke(input logic [4:0] rs, rt, rd,
    input logic [31:0] drs, drt, input logic reg_dst, rw,
    input logic [62:0] ctrl);
    ent_t e;
    e.rs = rs; e.rt = rt; e.rd = rd;
    e.drs = drs; e.drt = drt;
    e.reg_dst = reg_dst; e.rw = rw; e.ctrl = ctrl;
    return e;
  endfunction

  function automatic exp_t mkx(input logic [31:0] drs, drt,
    input logic [4:0] dest, input logic rw, input logic [62:0] ctrl);
    exp_t x;
    x.drs = drs; x.drt = drt; x.dest = dest;
    x.rw = rw; x.ctrl = ctrl;
    return x;
  endfunction

  task automatic push(input ent_t e);
    fifo.push_back(e);
    q_empty = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, input int budget,
                            output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_valid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      failures++;
      $display("FAIL %s act=timeout exp=valid", nm);
    end
  endtask

  initial begin
    logic [62:0] ca, cb, cc, cd, ce, cf, cg, ch, ci, cs;
    int t0, t1;
    logic [15:0] s0, s1;

    is_rst = 1'b0; exe_rdy = 1'b1; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    cur = '0; q_empty = 1'b1;

    ca = mkc(1'b1, 1'b0, 1'b0, 16'h0010);
    cb = mkc(1'b1, 1'b0, 1'b0, 16'h0020);
    cc = mkc(1'b0, 1'b0, 1'b0, 16'h0030);
    cd = mkc(1'b0, 1'b0, 1'b1, 16'h0040);
    ce = mkc(1'b1, 1'b0, 1'b0, 16'h0050);
    cf = mkc(1'b1, 1'b1, 1'b0, 16'h0060);
    cg = mkc(1'b0, 1'b0, 1'b0, 16'h0070);
    ch = mkc(1'b0, 1'b0, 1'b0, 16'h0080);
    ci = mkc(1'b0, 1'b0, 1'b0, 16'h0090);
    cs = mkc(1'b1, 1'b0, 1'b0, 16'h00A0);

    // Reset with a non-empty queue
    push(mke(5'd1, 5'd2, 5'd5, 32'h11112222, 32'h33334444,
             1'b1, 1'b1, ca));
    sb.push_back(mkx(32'h11112222, 32'h33334444, 5'd5, 1'b1, ca));
    repeat (5) tick();
    @(negedge clk);
    chk("rst_re", {63'h0, q_re}, 64'h0);
    chk("rst_valid", {63'h0, o_valid}, 64'h0);
    chk("rst_rs", {32'h0, o_rs}, 64'h0);
    chk("rst_rt", {32'h0, o_rt}, 64'h0);
    chk("rst_dest", {59'h0, o_dest}, 64'h0);
    chk("rst_rw", {63'h0, o_rw}, 64'h0);
    chk("rst_ctrl", {1'b0, o_ctrl}, 64'h0);
    chk("rst_stall", {48'h0, o_stall}, 64'h0);

    // No hazard: issue 3 cycles after re
    @(posedge clk); #1;
    is_rst = 1'b1;
    @(negedge clk);
    chk("a_re", {63'h0, q_re}, 64'h1);
    t0 = cyc;
    wait_valid("a_valid", 10, t1);
    chk("a_latency", 64'(t1 - t0), 64'd3);
    chk("a_nostall", {48'h0, o_stall}, 64'h0);

    // RAW on reg 5, released by writeback with bypass
    tick();
    push(mke(5'd5, 5'd2, 5'd6, 32'hDEAD0000, 32'h0000BBBB,
             1'b1, 1'b1, cb));
    sb.push_back(mkx(32'hCAFE0005, 32'h0000BBBB, 5'd6, 1'b1, cb));
    repeat (4) tick();
    @(negedge clk);
    s0 = o_stall;
    repeat (3) tick();
    @(negedge clk);
    s1 = o_stall;
    chk("raw_stall_inc", {48'h0, s1 - s0}, 64'd3);
    chk("raw_hold", {63'h0, o_valid}, 64'h0);
    tick();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hCAFE0005;
    tick();
    wb_en = 1'b0;
    @(negedge clk);
    chk("raw_wait", {63'h0, o_valid}, 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("raw_issue", {63'h0, o_valid}, 64'h1);

    // Reg 0 dest never stalls; jal dest=31; back-to-back throughput
    tick();
    s0 = o_stall;
    push(mke(5'd3, 5'd4, 5'd0, 32'h0C0C0003, 32'h0C0C0004,
             1'b1, 1'b1, cc));
    push(mke(5'd0, 5'd0, 5'd9, 32'h0D0D0000, 32'h0D0D0001,
             1'b1, 1'b1, cd));
    sb.push_back(mkx(32'h0C0C0003, 32'h0C0C0004, 5'd0, 1'b1, cc));
    sb.push_back(mkx(32'h0D0D0000, 32'h0D0D0001, 5'd31, 1'b1, cd));
    wait_valid("c_valid", 10, t0);
    wait_valid("d_valid", 10, t1);
    chk("cd_spacing", 64'(t1 - t0), 64'd2);
    chk("r0_nostall", {48'h0, o_stall}, {48'h0, s0});

    // Backpressure, then issue dest=7 racing a writeback to 7
    tick();
    exe_rdy = 1'b0;
    push(mke(5'd3, 5'd4, 5'd7, 32'h0E0E0003, 32'h0E0E0004,
             1'b1, 1'b1, ce));
    sb.push_back(mkx(32'h0E0E0003, 32'h0E0E0004, 5'd7, 1'b1, ce));
    repeat (4) tick();
    push(mke(5'd7, 5'd11, 5'd12, 32'hDEAD0007, 32'h0F0F000B,
             1'b0, 1'b1, cf));
    sb.push_back(mkx(32'h0000F007, 32'h0F0F000B, 5'd11, 1'b1, cf));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_re", {63'h0, q_re}, 64'h0);
      chk("bp_valid", {63'h0, o_valid}, 64'h0);
      tick();
    end
    exe_rdy = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77770007;
    tick();
    wb_en = 1'b0;
    @(negedge clk);
    chk("sw_issue", {63'h0, o_valid}, 64'h1);
    repeat (3) tick();
    @(negedge clk);
    s0 = o_stall;
    repeat (3) tick();
    @(negedge clk);
    s1 = o_stall;
    chk("sw_busy_kept", {48'h0, s1 - s0}, 64'd3);
    chk("sw_hold", {63'h0, o_valid}, 64'h0);
    tick();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000F007;
    tick();
    wb_en = 1'b0;
    wait_valid("f_valid", 6, t0);

    // Flush during CAP drops that entry; the next pops normally
    repeat (3) tick();
    push(mke(5'd13, 5'd14, 5'd15, 32'h47470013, 32'h47470014,
             1'b1, 1'b1, cg));
    push(mke(5'd16, 5'd17, 5'd18, 32'h48480016, 32'h48480017,
             1'b1, 1'b1, ch));
    sb.push_back(mkx(32'h48480016, 32'h48480017, 5'd18, 1'b1, ch));
    @(negedge clk);
    chk("fl_re", {63'h0, q_re}, 64'h1);
    @(posedge clk); #1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_valid("h_valid", 10, t0);

    // Bypass in CAP for rs; rt=15 shows the flushed entry set no busy
    repeat (3) tick();
    push(mke(5'd10, 5'd15, 5'd20, 32'h5555000A, 32'h5555000F,
             1'b1, 1'b0, ci));
    sb.push_back(mkx(32'hABCD000A, 32'h5555000F, 5'd20, 1'b0, ci));
    tick();
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hABCD000A;
    tick();
    wb_en = 1'b0;
    wait_valid("i_valid", 8, t0);

    // Saturation: reg 6 stays busy forever
    tick();
    push(mke(5'd6, 5'd0, 5'd21, 32'h0, 32'h0, 1'b1, 1'b0, cs));
    repeat (70000) tick();
    @(negedge clk);
    chk("stall_sat", {48'h0, o_stall}, 64'h000000000000FFFF);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
